lorenz_sampler: RTL and testbench
=================================

# lorenz_sampler

Downstream consumer of the Lorenz x/y/z integrator bank. Once per accepted integration step it decimates the 7.20 state stream and projects one selected plane onto 640x480 screen coordinates. It clamps off-screen points and buffers them in a small FIFO. The FIFO has a valid/ready handshake toward the VGA pixel writer, which draws the attractor.

## Interface
Parameters:
- DEPTH, 16: FIFO entries, power of two, at least 4.
- SHIFT, 17: arithmetic right shift from 7.20 to pixels; 17 gives 8 px per unit.
- X_OFFSET, 320: screen column of the origin.
- Y_OFFSET, 240: screen row of the origin.
- SCREEN_W, 640; SCREEN_H, 480: clamp limits.

Ports:
- clk, in, 1: the only clock.
- reset, in, 1: synchronous, active-high.
- step, in, 1: integrators latched new x/y/z this cycle.
- x_in, y_in, z_in, in, 27 each: signed 7.20 state variables.
- plane_sel, in, 2: 0 selects (x,y); 1 and 3 select (x,z); 2 selects (y,z).
- decim, in, 16: keep one step in every decim+1.
- out_valid, out, 1: FIFO head is valid.
- out_ready, in, 1: consumer accepts the head.
- out_px, out, 10: column.
- out_py, out, 9: row.
- out_clip, out, 1: point was clamped.
- drop_cnt, out, 16: points lost to a full FIFO; saturates.
- fill, out, $clog2(DEPTH)+1: current occupancy.

## Operation
- Decimation:
  - A 16-bit step counter advances on each step.
  - On a step with cnt >= decim, the block samples and clears cnt to 0.
  - Otherwise cnt increments.
  - Using >= means a runtime decrease of decim takes effect on the next step.
- Stage 1, registered on a sample: latch the horizontal source h and vertical source v chosen by plane_sel.
- Stage 2, registered:
  - Horizontal: ph = X_OFFSET + (h >>> SHIFT).
  - Vertical: pv = Y_OFFSET - (v >>> SHIFT). Screen y is inverted.
  - Do the arithmetic signed at 28 bits so the sum cannot wrap.
  - Clamp ph to 0..SCREEN_W-1 and pv to 0..SCREEN_H-1.
  - clip = 1 if either value was clamped.
- Push: a stage-2 valid point is written into the FIFO.
  - If the FIFO is full and no pop happens that cycle, drop the point and increment drop_cnt, saturating at 0xFFFF.
- Pop: occurs when out_valid && out_ready. The FIFO is show-ahead; out_px/py/clip always show the head entry.
- Simultaneous push and pop when full: both succeed, fill stays DEPTH, nothing is dropped.
- Simultaneous push and pop when empty: the pushed point appears on the next cycle. There is no same-cycle bypass.

## Timing
- Reset takes effect at the next edge:
  - cnt, pipeline valids, and FIFO pointers clear.
  - fill = 0, out_valid = 0, out_px = 0, out_py = 0, out_clip = 0, drop_cnt = 0.
- Reset during operation discards all in-flight and buffered points.
- Latency:
  - step is sampled at edge N, stage 2 is valid after edge N+1, and the FIFO write occurs at edge N+2.
  - When the FIFO was empty, out_valid is high after edge N+2.
- Throughput is one point per cycle, sustained with decim = 0 and out_ready held high.
- The output contents are stable while out_valid && !out_ready.
- fill updates on the same edge as the push or pop.

## Structure
- Shared package lorenz_pkg holds:
  - FP_W = 27 and FP_FRAC = 20.
  - The screen dimensions.
  - The typedef point_t: px[9:0], py[8:0], clip.
  - The plane_sel encodings.
- Sub-module sample_fifo is a synchronous show-ahead FIFO of point_t, parameterised by DEPTH. It provides push/pop/full/empty/fill, uses no resets on the storage array, and resets only the pointers.

## Test plan
- Basic projection:
  - Stimulus: decim = 0, plane_sel = 0, x = 1.0 (0x0100000), y = -2.0, one step, out_ready = 1.
  - Required: after 2 cycles out_valid = 1 with px = 328, py = 256, clip = 0.
- Clamping:
  - Stimulus: x = 63.0, y = 63.0, one step.
  - Required: px = 639, py = 0, clip = 1.
- Decimation:
  - Stimulus: decim = 3, 12 consecutive steps.
  - Required: exactly 3 points, from steps 4, 8 and 12. Changing decim to 0 mid-run samples on the very next step.
- Back-pressure and overflow:
  - Stimulus: out_ready = 0, 20 sampled steps with DEPTH = 16.
  - Required: fill = 16 and drop_cnt = 4. Then out_ready = 1 drains the first 16 points in order.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, out_ready = 1 pulsed together with a sample.
  - Required: fill stays 16 and drop_cnt is unchanged.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle with the FIFO at 5 entries and a point in stage 2.
  - Required: out_valid = 0 and fill = 0 after the edge, and the in-flight point never appears.

Source files
------------

// File: rtl/lorenz_pkg.sv
// Shared types and constants for the Lorenz attractor sampling path.
package lorenz_pkg;

    // Integrator state format: signed 7.20 fixed point.
    localparam int FP_W    = 27;
    localparam int FP_FRAC = 20;

    // Target screen geometry.
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // One projected screen point as stored in the output FIFO.
    typedef struct packed {
        logic [9:0] px;
        logic [8:0] py;
        logic       clip;
    } point_t;

    // Projection plane encodings; 3 aliases the (x,z) plane.
    typedef enum logic [1:0] {
        PLANE_XY     = 2'd0,
        PLANE_XZ     = 2'd1,
        PLANE_YZ     = 2'd2,
        PLANE_XZ_ALT = 2'd3
    } plane_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO of screen points; head entry is always on dout.
module sample_fifo
    import lorenz_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  point_t                 din,
    input  logic                   pop,
    output point_t                 dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fill
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    point_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fill    = wr_ptr - rd_ptr;
    assign full    = (fill == FULL_CNT);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage write.
    // NOTE: the array has no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/lorenz_sampler.sv
// Decimates the Lorenz state stream, projects one plane to screen pixels,
// clamps to the visible area and buffers points for the VGA pixel writer.
module lorenz_sampler
    import lorenz_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SHIFT    = 17,
    parameter int X_OFFSET = 320,
    parameter int Y_OFFSET = 240,
    parameter int SCREEN_W = lorenz_pkg::SCREEN_W,
    parameter int SCREEN_H = lorenz_pkg::SCREEN_H
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step,
    input  logic signed [FP_W-1:0] x_in,
    input  logic signed [FP_W-1:0] y_in,
    input  logic signed [FP_W-1:0] z_in,
    input  logic [1:0]             plane_sel,
    input  logic [15:0]            decim,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [9:0]             out_px,
    output logic [8:0]             out_py,
    output logic                   out_clip,
    output logic [15:0]            drop_cnt,
    output logic [$clog2(DEPTH):0] fill
);

    // 28-bit signed arithmetic leaves headroom so offset plus shifted state never wraps.
    localparam logic signed [27:0] X_OFF = 28'(X_OFFSET);
    localparam logic signed [27:0] Y_OFF = 28'(Y_OFFSET);
    localparam logic signed [27:0] X_MAX = 28'(SCREEN_W - 1);
    localparam logic signed [27:0] Y_MAX = 28'(SCREEN_H - 1);

    logic [15:0]            cnt;
    logic                   sample;
    logic signed [FP_W-1:0] src_h;
    logic signed [FP_W-1:0] src_v;
    logic                   s1_valid;
    logic signed [FP_W-1:0] s1_h;
    logic signed [FP_W-1:0] s1_v;
    logic signed [27:0]     h_ext;
    logic signed [27:0]     v_ext;
    logic signed [27:0]     ph;
    logic signed [27:0]     pv;
    point_t                 pt_next;
    logic                   s2_valid;
    point_t                 s2_pt;
    point_t                 head;
    logic                   full;
    logic                   empty;
    logic                   pop;

    // Comparing with >= lets a lowered decim take effect on the very next step.
    assign sample = step && (cnt >= decim);

    // Step counter: keep one step in every decim+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= sample ? 16'd0 : cnt + 16'd1;
        end
    end

    // Select horizontal and vertical sources for the chosen plane.
    // NOTE: defaults assigned first so no path through the block can infer a latch.
    always_comb begin
        src_h = x_in;
        src_v = y_in;
        case (plane_t'(plane_sel))
            PLANE_XY: begin src_h = x_in; src_v = y_in; end
            PLANE_YZ: begin src_h = y_in; src_v = z_in; end
            default:  begin src_h = x_in; src_v = z_in; end
        endcase
    end

    // Stage 1: capture the selected pair on a sample; only the valid bit is reset.
    always_ff @(posedge clk) begin
        if (reset) s1_valid <= 1'b0;
        else       s1_valid <= sample;
        if (sample) begin
            s1_h <= src_h;
            s1_v <= src_v;
        end
    end

    // Project to screen space (y inverted) and clamp to the visible area.
    always_comb begin
        h_ext   = 28'(s1_h);
        v_ext   = 28'(s1_v);
        ph      = X_OFF + (h_ext >>> SHIFT);
        pv      = Y_OFF - (v_ext >>> SHIFT);
        pt_next = '0;
        if (ph < 28'sd0) begin
            pt_next.px   = '0;
            pt_next.clip = 1'b1;
        end else if (ph > X_MAX) begin
            pt_next.px   = X_MAX[9:0];
            pt_next.clip = 1'b1;
        end else begin
            pt_next.px = ph[9:0];
        end
        if (pv < 28'sd0) begin
            pt_next.py   = '0;
            pt_next.clip = 1'b1;
        end else if (pv > Y_MAX) begin
            pt_next.py   = Y_MAX[8:0];
            pt_next.clip = 1'b1;
        end else begin
            pt_next.py = pv[8:0];
        end
    end

    // Stage 2: register the projected point.
    always_ff @(posedge clk) begin
        if (reset) s2_valid <= 1'b0;
        else       s2_valid <= s1_valid;
        s2_pt <= pt_next;
    end

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s2_valid),
        .din   (s2_pt),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .fill  (fill)
    );

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // Head data is masked while empty so stale storage never reaches the port.
    assign out_px    = out_valid ? head.px   : '0;
    assign out_py    = out_valid ? head.py   : '0;
    assign out_clip  = out_valid ? head.clip : 1'b0;

    // Count points lost to a full FIFO, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (s2_valid && full && !pop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lorenz_sampler.sv
// Self-checking bench for lorenz_sampler against a behavioural point-queue model.
module tb_lorenz_sampler;
    import lorenz_pkg::*;

    localparam int DEPTH = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   step;
    logic signed [FP_W-1:0] x_in;
    logic signed [FP_W-1:0] y_in;
    logic signed [FP_W-1:0] z_in;
    logic [1:0]             plane_sel;
    logic [15:0]            decim;
    logic                   out_valid;
    logic                   out_ready;
    logic [9:0]             out_px;
    logic [8:0]             out_py;
    logic                   out_clip;
    logic [15:0]            drop_cnt;
    logic [4:0]             fill;

    always #5 clk = ~clk;

    lorenz_sampler #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .plane_sel (plane_sel),
        .decim     (decim),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_px    (out_px),
        .out_py    (out_py),
        .out_clip  (out_clip),
        .drop_cnt  (drop_cnt),
        .fill      (fill)
    );

    typedef struct {
        bit v;
        int px;
        int py;
        bit clip;
    } mpt_t;

    mpt_t pipe[$];   // sampled points still travelling toward the FIFO (two-edge delay)
    mpt_t q[$];      // expected FIFO contents, head first
    int   m_cnt;
    int   m_drop;
    int   checks = 0;
    int   errors = 0;
    int   dut_pops = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Screen projection from first principles: 8 px per unit, floor rounding, clamp.
    function automatic mpt_t project(input int h, input int v);
        mpt_t p;
        int   ph;
        int   pv;
        ph = 320 + $rtoi($floor(real'(h) / 131072.0));
        pv = 240 - $rtoi($floor(real'(v) / 131072.0));
        p.v    = 1'b1;
        p.clip = 1'b0;
        if (ph < 0)        begin ph = 0;   p.clip = 1'b1; end
        else if (ph > 639) begin ph = 639; p.clip = 1'b1; end
        if (pv < 0)        begin pv = 0;   p.clip = 1'b1; end
        else if (pv > 479) begin pv = 479; p.clip = 1'b1; end
        p.px = ph;
        p.py = pv;
        return p;
    endfunction

    task automatic model_reset();
        mpt_t none;
        none = '{v: 1'b0, px: 0, py: 0, clip: 1'b0};
        q.delete();
        pipe.delete();
        pipe.push_back(none);
        pipe.push_back(none);
        m_cnt  = 0;
        m_drop = 0;
    endtask

    // Apply the effect of one clock edge to the model, using pre-edge inputs.
    task automatic model_edge(input bit rst_v, input bit step_v, input bit ready_v);
        mpt_t nxt;
        mpt_t arriving;
        bit   do_pop;
        int   hx;
        int   vx;
        if (rst_v) begin
            model_reset();
            return;
        end
        nxt      = '{v: 1'b0, px: 0, py: 0, clip: 1'b0};
        do_pop   = ready_v && (q.size() > 0);
        arriving = pipe.pop_front();
        if (step_v) begin
            if (m_cnt >= int'(decim)) begin
                m_cnt = 0;
                case (plane_sel)
                    2'd0:    begin hx = int'(x_in); vx = int'(y_in); end
                    2'd2:    begin hx = int'(y_in); vx = int'(z_in); end
                    default: begin hx = int'(x_in); vx = int'(z_in); end
                endcase
                nxt = project(hx, vx);
            end else begin
                m_cnt++;
            end
        end
        pipe.push_back(nxt);
        if (do_pop) void'(q.pop_front());
        if (arriving.v) begin
            if (q.size() >= DEPTH) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                q.push_back(arriving);
            end
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("fill", 32'(fill), 32'(q.size()));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (q.size() != 0) begin
            check("out_px", 32'(out_px), 32'(q[0].px));
            check("out_py", 32'(out_py), 32'(q[0].py));
            check("out_clip", 32'(out_clip), 32'(q[0].clip));
        end else begin
            check("out_px_idle", 32'(out_px), 32'd0);
            check("out_py_idle", 32'(out_py), 32'd0);
            check("out_clip_idle", 32'(out_clip), 32'd0);
        end
    endtask

    // Drive one cycle, advance the model, then sample outputs 1 ns after the edge.
    task automatic tick(input bit rst_v, input bit step_v, input bit ready_v);
        reset     = rst_v;
        step      = step_v;
        out_ready = ready_v;
        if (out_valid && ready_v && !rst_v) dut_pops++;
        model_edge(rst_v, step_v, ready_v);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic rand_state();
        int r;
        if ($urandom_range(0, 1) == 0) begin
            x_in = FP_W'($urandom);
            y_in = FP_W'($urandom);
            z_in = FP_W'($urandom);
        end else begin
            r = $urandom_range(0, 83886080) - 41943040; x_in = FP_W'(r);
            r = $urandom_range(0, 83886080) - 41943040; y_in = FP_W'(r);
            r = $urandom_range(0, 83886080) - 41943040; z_in = FP_W'(r);
        end
    endtask

    initial begin
        reset     = 1'b1;
        step      = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        plane_sel = 2'd0;
        decim     = 16'd0;
        model_reset();

        // Reset state
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_fill", 32'(fill), 32'd0);

        // Basic projection: x = 1.0, y = -2.0 on the (x,y) plane
        decim     = 16'd0;
        plane_sel = 2'd0;
        x_in      = 27'sh0100000;
        y_in      = -27'sh0200000;
        tick(1'b0, 1'b1, 1'b1);
        x_in = '0;
        y_in = '0;
        tick(1'b0, 1'b0, 1'b1);
        check("basic_not_early", 32'(out_valid), 32'd0);
        tick(1'b0, 1'b0, 1'b1);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_px", 32'(out_px), 32'd328);
        check("basic_py", 32'(out_py), 32'd256);
        check("basic_clip", 32'(out_clip), 32'd0);
        tick(1'b0, 1'b0, 1'b1);

        // Clamping: x = y = 63.0
        x_in = 27'sh3F00000;
        y_in = 27'sh3F00000;
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("clamp_px", 32'(out_px), 32'd639);
        check("clamp_py", 32'(out_py), 32'd0);
        check("clamp_clip", 32'(out_clip), 32'd1);
        tick(1'b0, 1'b0, 1'b1);

        // Randomized traffic over all planes, small decim, random back-pressure
        for (int i = 0; i < 300; i++) begin
            rand_state();
            plane_sel = 2'($urandom_range(0, 3));
            decim     = 16'($urandom_range(0, 2));
            tick(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        decim = 16'd0;
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b1);

        // Decimation: decim = 3, 12 steps -> points from steps 4, 8, 12
        tick(1'b1, 1'b0, 1'b1);
        decim    = 16'd3;
        dut_pops = 0;
        for (int i = 0; i < 12; i++) begin
            rand_state();
            tick(1'b0, 1'b1, 1'b1);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1);
        check("decim_points", 32'(dut_pops), 32'd3);

        // Lowering decim mid-run samples on the very next step
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        decim    = 16'd0;
        dut_pops = 0;
        rand_state();
        tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1);
        check("decim_change_points", 32'(dut_pops), 32'd1);

        // Back-pressure and overflow: 20 samples into 16 entries
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            rand_state();
            plane_sel = 2'($urandom_range(0, 3));
            tick(1'b0, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("overflow_fill", 32'(fill), 32'd16);
        check("overflow_drops", 32'(drop_cnt), 32'd4);

        // Full FIFO with a push and pop on the same edge
        rand_state();
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        check("full_pushpop_fill", 32'(fill), 32'd16);
        check("full_pushpop_drops", 32'(drop_cnt), 32'd4);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1);
        check("drained_fill", 32'(fill), 32'd0);

        // Reset mid-stream with 5 buffered points and one point in stage 2
        for (int i = 0; i < 5; i++) begin
            rand_state();
            tick(1'b0, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("pre_reset_fill", 32'(fill), 32'd5);
        rand_state();
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        check("midreset_valid", 32'(out_valid), 32'd0);
        check("midreset_fill", 32'(fill), 32'd0);
        dut_pops = 0;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1);
        check("midreset_no_ghost", 32'(dut_pops), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
